// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Fixed-latency data memory controller downstream of the load/store unit.
//   Takes one load or store at a time. Stores are placed into byte lanes.
//   Loads are extracted right-aligned and zero-filled. A one-cycle ready
//   pulse marks completion. Sign extension is left to the load/store unit.
//
// Parameters
//   ADDR_W   byte-address bits used; memory holds 2^(ADDR_W-2) 32-bit words
//   LATENCY  cycles from the request cycle to the ready cycle (2..15)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   req         request strobe
//   read_write  0 = load, 1 = store
//   size        00 byte, 01 half, 10 word, 11 illegal
//   addr        byte address; bits above ADDR_W-1 are ignored
//   wdata       right-aligned store data
//   busy        request in flight, new requests are dropped
//   ready       one-cycle completion pulse
//   err         misaligned or illegal request, only in the ready cycle
//   rdata       load result, right-aligned, upper bits zero
module data_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        read_write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int         DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAST  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept;
    logic        finish;

    // Captured request
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       mem_word;
    logic [31:0]       load_data;
    logic [31:0]       store_lanes;
    logic [3:0]        byte_en;
    logic              req_err;

    // Address wraps: the high bits are deliberately unused.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a variable unassigned (no latch).
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    count_next = 4'd1;
                end
            end
            WAIT: begin
                if (count == LAST) begin
                    state_next = DONE;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            DONE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    count_next = 4'd1;
                end else begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // The edge that enters DONE is where the memory and rdata/err update.
    assign finish = (state == WAIT) && (count == LAST);

    // ------------------------------------------------------------------
    // Request decode (from captured fields only)
    // ------------------------------------------------------------------
    assign word_idx = addr_q[ADDR_W-1:2];
    assign mem_word = mem[word_idx];

    assign req_err = (size_q == 2'b11)
                   || (size_q == 2'b01 && addr_q[0])
                   || (size_q == 2'b10 && addr_q[1:0] != 2'b00);

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                byte_en     = 4'b0001 << addr_q[1:0];
                store_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        load_data = mem_word;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    load_data = {24'b0, mem_word[7:0]};
                    2'd1:    load_data = {24'b0, mem_word[15:8]};
                    2'd2:    load_data = {24'b0, mem_word[23:16]};
                    default: load_data = {24'b0, mem_word[31:24]};
                endcase
            end
            2'b01:   load_data = addr_q[1] ? {16'b0, mem_word[31:16]}
                                           : {16'b0, mem_word[15:0]};
            default: load_data = mem_word;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of order.
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next == WAIT);
            ready <= (state_next == DONE);
            err   <= finish && req_err;
            // Any faulting request drives rdata to zero; good stores keep it.
            if (finish && (req_err || !rw_q)) begin
                rdata <= req_err ? 32'h0 : load_data;
            end
        end
    end

    // Request fields only matter once accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= read_write;
            size_q  <= size;
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------
    // NOTE: the array is never reset; reset only suppresses a pending
    // write, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && finish && rw_q && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Directed self-checking bench for data_mem_ctrl with default parameters
//   (ADDR_W = 10, LATENCY = 4). Inputs change 1 time unit after a rising
//   edge; outputs are sampled at the same point, i.e. at the start of a cycle.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        read_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    localparam logic       LD = 1'b0;
    localparam logic       ST = 1'b1;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    data_mem_ctrl #(
        .ADDR_W  (10),
        .LATENCY (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .read_write (read_write),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .ready      (ready),
        .err        (err),
        .rdata      (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle (cycle 0) and follows it to
    // its ready pulse. Returns the ready cycle (-1 on timeout), the rdata and
    // err seen then, and whether cycles 1..ready-1 all showed busy=1, err=0.
    // Returns at the start of the ready cycle with req low.
    task automatic run_op(input logic rw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic er, output logic wait_ok);
        bit done;
        req = 1'b1; read_write = rw; size = sz; addr = a; wdata = wd;
        step();
        req = 1'b0;
        lat = -1; rd = 32'h0; er = 1'b0; wait_ok = 1'b1; done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            if (ready) begin
                lat = c; rd = rdata; er = err;
                if (busy) wait_ok = 1'b0;
                done = 1;
            end else begin
                if (!busy || err) wait_ok = 1'b0;
                step();
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; read_write = 1'b0;
        size = 2'b00; addr = 32'h0; wdata = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er, ok;
        run_op(ST, SZ_W, 32'h010, 32'hDEADBEEF, lat, rd, er, ok);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sw_latency: got %0d want 4", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_busy_window: got %b want 1", ok); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_keeps_rdata: got %h want 00000000", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", er); end
        // Issued in the store's ready cycle: back-to-back read-after-write.
        run_op(LD, SZ_W, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency: got %0d want 4", lat); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw_busy_window: got %b want 1", ok); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_raw_data: got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", er); end
        // Address wrap: bit 10 and above are ignored.
        run_op(LD, SZ_W, 32'h0000_0410, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wrap: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er, ok;
        run_op(ST, SZ_B, 32'h012, 32'h000000AA, lat, rd, er, ok);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err: got %b want 0", er); end
        run_op(LD, SZ_W, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL sb_lw: got %h want deaabeef", rd); end
        run_op(LD, SZ_B, 32'h013, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_3: got %h want 000000de", rd); end
        run_op(LD, SZ_B, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu_0: got %h want 000000ef", rd); end
        run_op(LD, SZ_B, 32'h011, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL lbu_1: got %h want 000000be", rd); end
    endtask

    task automatic test_half();
        int lat; logic [31:0] rd; logic er, ok;
        run_op(ST, SZ_H, 32'h012, 32'h00001234, lat, rd, er, ok);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_err: got %b want 0", er); end
        run_op(LD, SZ_H, 32'h012, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_hi: got %h want 00001234", rd); end
        run_op(LD, SZ_W, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL sh_lw: got %h want 1234beef", rd); end
        run_op(LD, SZ_H, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lh_lo: got %h want 0000beef", rd); end
    endtask

    task automatic test_error();
        int lat; logic [31:0] rd; logic er, ok;
        run_op(LD, SZ_W, 32'h011, 32'h0, lat, rd, er, ok);
        checks++; if (lat !== 4) begin errors++; $display("FAIL lw_mis_latency: got %0d want 4", lat); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lw_mis_err: got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw_mis_rdata: got %h want 00000000", rd); end
        req = 1'b0;
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_done: got %b want 0", err); end
        run_op(LD, SZ_W, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h1234BEEF || er !== 1'b0) begin errors++; $display("FAIL lw_after_err: got %h/%b want 1234beef/0", rd, er); end
        run_op(ST, SZ_H, 32'h013, 32'h0000FFFF, lat, rd, er, ok);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_mis_err: got %b want 1", er); end
        run_op(ST, SZ_X, 32'h010, 32'hFFFFFFFF, lat, rd, er, ok);
        checks++; if (er !== 1'b1 || lat !== 4) begin errors++; $display("FAIL size11_err: got err %b lat %0d want 1/4", er, lat); end
        run_op(LD, SZ_W, 32'h010, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL no_write_on_err: got %h want 1234beef", rd); end
    endtask

    task automatic test_busy_drop();
        int pulses;
        req = 1'b0;
        step();                       // now idle
        req = 1'b1; read_write = LD; size = SZ_W; addr = 32'h010; wdata = 32'h0;
        step();                       // cycle 1
        req = 1'b0;
        step();                       // cycle 2
        req = 1'b1;
        step();                       // cycle 3
        req = 1'b0;
        step();                       // cycle 4
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL drop_ready_c4: got %b want 1", ready); end
        checks++; if (rdata !== 32'h1234BEEF) begin errors++; $display("FAIL drop_rdata: got %h want 1234beef", rdata); end
        pulses = 0;
        for (int c = 5; c <= 12; c++) begin
            step();
            if (ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL drop_extra_ready: got %0d want 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ready_vec;
        logic [11:0] busy_vec;
        ready_vec = '0;
        busy_vec  = '0;
        req = 1'b1; read_write = LD; size = SZ_W; addr = 32'h010; wdata = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            step();
            ready_vec[c-1] = ready;
            busy_vec[c-1]  = busy;
            if (c == 12) req = 1'b0;
        end
        checks++; if (ready_vec !== 12'h888) begin errors++; $display("FAIL b2b_ready: got %h want 888", ready_vec); end
        checks++; if (busy_vec !== 12'h777) begin errors++; $display("FAIL b2b_busy: got %h want 777", busy_vec); end
        step();
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b ready %b want 0/0", busy, ready); end
    endtask

    task automatic test_reset_mid();
        int lat; int pulses; logic [31:0] rd; logic er, ok;
        req = 1'b1; read_write = ST; size = SZ_W; addr = 32'h020; wdata = 32'h11111111;
        step();                       // cycle 1
        req = 1'b0;
        step();                       // cycle 2
        reset = 1'b1;
        step();                       // cycle 3
        reset = 1'b0;
        checks++; if ({busy, ready, err} !== 3'b000 || rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy %b ready %b err %b rdata %h want 0", busy, ready, err, rdata);
        end
        pulses = 0;
        for (int c = 4; c <= 8; c++) begin
            step();
            if (ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_reset_ready: got %0d want 0", pulses); end
        run_op(LD, SZ_W, 32'h020, 32'h0, lat, rd, er, ok);
        checks++; if (rd !== 32'h0 || lat !== 4) begin errors++; $display("FAIL mid_reset_nowrite: got %h lat %0d want 00000000/4", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_error();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
